// File: rtl/glitch_reset_monitor.sv
// Watches the target's reset/boot pin, rejects runt pulses, measures valid pulse width
// and fires a one-cycle trigger when the target comes out of reset.
module glitch_reset_monitor #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int MIN_WIDTH  = 4,
  parameter int WIDTH_W    = 16,
  parameter int TIMEOUT    = 1000000,
  parameter int TO_W       = 24
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               abort,
  input  logic               tgt_rst,
  output logic               ready,
  output logic               trig,
  output logic               done,
  output logic               timeout,
  output logic [WIDTH_W-1:0] width
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_REL    = 3'd1,
    WAIT_ASSERT = 3'd2,
    IN_RESET    = 3'd3,
    FINISH      = 3'd4
  } state_t;

  // Pin level that means "target running"; the synchronizer resets to it.
  localparam logic              IDLE_LVL = ACTIVE_LOW;
  localparam logic [WIDTH_W-1:0] W_ONE   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] W_MAX   = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] MIN_W   = WIDTH_W'(MIN_WIDTH);
  localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);
  localparam bit                 TO_EN   = (TIMEOUT != 0);

  logic               sync1_r, sync2_r;
  logic               line_a_s;
  logic               to_expired_s;
  state_t             state_r, state_s;
  logic [TO_W-1:0]    to_cnt_r, to_cnt_s;
  logic [WIDTH_W-1:0] w_cnt_r, w_cnt_s;
  logic [WIDTH_W-1:0] width_r, width_s;
  logic               timeout_r, timeout_s;
  logic               trig_r, trig_s;
  logic               done_r, done_s;

  // Two-flop synchronizer for the asynchronous target reset pin
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= tgt_rst;
      sync2_r <= sync1_r;
    end
  end

  assign line_a_s     = ACTIVE_LOW ? ~sync2_r : sync2_r;
  assign to_expired_s = TO_EN && (to_cnt_r >= TO_LAST);

  // State, counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      to_cnt_r  <= {TO_W{1'b0}};
      w_cnt_r   <= {WIDTH_W{1'b0}};
      width_r   <= {WIDTH_W{1'b0}};
      timeout_r <= 1'b0;
      trig_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      to_cnt_r  <= to_cnt_s;
      w_cnt_r   <= w_cnt_s;
      width_r   <= width_s;
      timeout_r <= timeout_s;
      trig_r    <= trig_s;
      done_r    <= done_s;
    end
  end

  // Next-state and next-output decode; abort outranks release and timeout
  always_comb begin
    state_s   = state_r;
    to_cnt_s  = to_cnt_r;
    w_cnt_s   = w_cnt_r;
    width_s   = width_r;
    timeout_s = timeout_r;
    trig_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s   = WAIT_REL;
          timeout_s = 1'b0;
          width_s   = {WIDTH_W{1'b0}};
          to_cnt_s  = {TO_W{1'b0}};
          w_cnt_s   = {WIDTH_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_REL: begin
        if (abort) begin
          state_s = IDLE;
        end else if (!line_a_s) begin
          state_s  = WAIT_ASSERT;
          to_cnt_s = to_cnt_r + TO_ONE;
        end else if (to_expired_s) begin
          state_s   = FINISH;
          timeout_s = 1'b1;
          done_s    = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end
      WAIT_ASSERT: begin
        if (abort) begin
          state_s = IDLE;
        end else if (line_a_s) begin
          state_s  = IN_RESET;
          w_cnt_s  = W_ONE;
          to_cnt_s = to_cnt_r + TO_ONE;
        end else if (to_expired_s) begin
          state_s   = FINISH;
          timeout_s = 1'b1;
          done_s    = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end
      IN_RESET: begin
        if (abort) begin
          state_s = IDLE;
        end else if (line_a_s) begin
          if (w_cnt_r != W_MAX) begin
            w_cnt_s = w_cnt_r + W_ONE;
          end else begin
            w_cnt_s = w_cnt_r;
          end
        end else if (w_cnt_r < MIN_W) begin
          state_s = WAIT_ASSERT;
          w_cnt_s = {WIDTH_W{1'b0}};
        end else begin
          state_s = FINISH;
          width_s = w_cnt_r;
          trig_s  = 1'b1;
          done_s  = 1'b1;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign ready   = (state_r == IDLE);
  assign trig    = trig_r;
  assign done    = done_r;
  assign timeout = timeout_r;
  assign width   = width_r;

endmodule

// File: tb/tb_glitch_reset_monitor.sv
// Bench for glitch_reset_monitor: directed scenarios plus random pin waveforms scored
// against a run-length model of the expected measurement outcome.
module tb_glitch_reset_monitor;

  localparam int T_A    = 50;
  localparam int MINW   = 4;
  localparam int WMAX_A = 65535;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en_a, abort_a, pin_a;
  logic        ready_a, trig_a, done_a, timeout_a;
  logic [15:0] width_a;
  logic        en_b, abort_b, pin_b;
  logic        ready_b, trig_b, done_b, timeout_b;
  logic [3:0]  width_b;

  int total = 0;
  int bad   = 0;

  bit seq_q[$];
  bit init_g;
  int m_d, m_w;
  bit m_valid, m_to;

  always #5 clk_in = ~clk_in;

  glitch_reset_monitor #(.ACTIVE_LOW(1'b1), .MIN_WIDTH(MINW), .WIDTH_W(16),
                         .TIMEOUT(T_A), .TO_W(24)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .en(en_a), .abort(abort_a), .tgt_rst(pin_a),
    .ready(ready_a), .trig(trig_a), .done(done_a), .timeout(timeout_a), .width(width_a));

  glitch_reset_monitor #(.ACTIVE_LOW(1'b0), .MIN_WIDTH(MINW), .WIDTH_W(4),
                         .TIMEOUT(0), .TO_W(24)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .en(en_b), .abort(abort_b), .tgt_rst(pin_b),
    .ready(ready_b), .trig(trig_b), .done(done_b), .timeout(timeout_b), .width(width_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Asserted state the monitor sees at FSM edge n (arm edge = 0); pin is init before edge 1.
  function automatic bit line_at(int n);
    if (n <= 2) return init_g;
    if (n - 3 < seq_q.size()) return seq_q[n-3];
    return 1'b0;
  endfunction

  // Outcome from run lengths: skip a pulse already in progress, ignore runts, spend at most
  // T_A waiting cycles (pulse cycles excluded) before declaring a timeout.
  task automatic model();
    int n, waited, len;
    n = 1; waited = 0;
    m_valid = 1'b0; m_to = 1'b0; m_w = 0; m_d = 0;
    while (line_at(n)) begin
      if (waited >= T_A - 1) begin m_to = 1'b1; m_d = n; return; end
      waited++; n++;
    end
    waited++; n++;
    while (n < 5000) begin
      while (!line_at(n)) begin
        if (waited >= T_A - 1) begin m_to = 1'b1; m_d = n; return; end
        waited++; n++;
      end
      waited++;
      len = 0;
      while (line_at(n + len)) len++;
      if (len >= MINW) begin
        m_valid = 1'b1;
        m_d     = n + len;
        m_w     = (len > WMAX_A) ? WMAX_A : len;
        return;
      end
      n = n + len + 1;
    end
  endtask

  task automatic add_run(input bit v, input int cnt);
    repeat (cnt) seq_q.push_back(v);
  endtask

  task automatic run_meas(input string tag);
    @(negedge clk_in);
    en_a  = 1'b0;
    pin_a = ~init_g;
    repeat (3) @(negedge clk_in);
    model();
    en_a = 1'b1;
    @(negedge clk_in);
    en_a = 1'b0;
    chk({tag, "_armed_ready"}, ready_a, 0);
    chk({tag, "_armed_timeout"}, timeout_a, 0);
    chk({tag, "_armed_width"}, width_a, 0);
    pin_a = ~((seq_q.size() > 0) ? seq_q[0] : 1'b0);
    for (int e = 1; e <= m_d + 1; e++) begin
      @(negedge clk_in);
      pin_a = ~((e < seq_q.size()) ? seq_q[e] : 1'b0);
      if (e < m_d) begin
        chk({tag, "_quiet"}, {trig_a, done_a}, 0);
      end else if (e == m_d) begin
        chk({tag, "_done"}, done_a, 1);
        chk({tag, "_trig"}, trig_a, m_valid);
        chk({tag, "_timeout"}, timeout_a, m_to);
        chk({tag, "_width"}, width_a, m_valid ? m_w : 0);
      end else begin
        chk({tag, "_ready_after"}, ready_a, 1);
        chk({tag, "_done_after"}, done_a, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en_a = 1'b0; abort_a = 1'b0; pin_a = 1'b1;
    en_b = 1'b0; abort_b = 1'b0; pin_b = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_outs_a", {trig_a, done_a, timeout_a}, 0);
    chk("rst_width_a", width_a, 0);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_width_b", width_b, 0);
    rst_n = 1'b1;

    // Plain 20-cycle pulse, then a soft reset clears the held width
    seq_q.delete(); init_g = 1'b0; add_run(1'b0, 3); add_run(1'b1, 20);
    run_meas("p20");
    chk("p20_width_held", width_a, 20);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    chk("rst_clears_width", width_a, 0);
    chk("rst_ready_idle", ready_a, 1);

    // Runt of 2 ignored, following 10-cycle pulse measured
    seq_q.delete(); init_g = 1'b0;
    add_run(1'b0, 2); add_run(1'b1, 2); add_run(1'b0, 3); add_run(1'b1, 10);
    run_meas("runt");
    chk("runt_width_held", width_a, 10);

    // Already in reset at arm: first pulse skipped, next 8-cycle pulse measured
    seq_q.delete(); init_g = 1'b1;
    add_run(1'b1, 5); add_run(1'b0, 4); add_run(1'b1, 8);
    run_meas("preasserted");
    chk("pre_width_held", width_a, 8);

    // Idle line: timeout after 50 cycles, then reset clears the sticky flag
    seq_q.delete(); init_g = 1'b0;
    run_meas("idle_to");
    chk("to_sticky", timeout_a, 1);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    chk("rst_clears_timeout", timeout_a, 0);

    // Abort five cycles into an asserted pulse
    pin_a = 1'b1;
    repeat (3) @(negedge clk_in);
    en_a = 1'b1;
    @(negedge clk_in);
    en_a = 1'b0; pin_a = 1'b0;
    repeat (4) @(negedge clk_in);
    abort_a = 1'b1;
    @(negedge clk_in);
    abort_a = 1'b0;
    chk("abort_ready", ready_a, 1);
    chk("abort_outs", {trig_a, done_a, timeout_a}, 0);
    for (int e = 0; e < 10; e++) begin
      @(negedge clk_in);
      if (e == 2) pin_a = 1'b1;
      chk("abort_no_done", {ready_a, trig_a, done_a}, 3'b100);
    end

    // Reset in the middle of a pulse
    en_a = 1'b1;
    @(negedge clk_in);
    en_a = 1'b0; pin_a = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("midpulse_busy", ready_a, 0);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    chk("midrst_ready", ready_a, 1);
    chk("midrst_outs", {trig_a, done_a, timeout_a}, 0);
    pin_a = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk_in);
      chk("midrst_quiet", {ready_a, trig_a, done_a}, 3'b100);
    end

    // Active-high, 4-bit width: 40-cycle pulse saturates, en while busy ignored
    en_b = 1'b1;
    @(negedge clk_in);
    en_b = 1'b0; pin_b = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk_in);
      if (e == 9) en_b = 1'b1;
      else en_b = 1'b0;
      if (e == 40) pin_b = 1'b0;
      if (e < 43) begin
        chk("b_busy", {ready_b, done_b, trig_b}, 3'b000);
      end else if (e == 43) begin
        chk("b_done", done_b, 1);
        chk("b_trig", trig_b, 1);
        chk("b_width_sat", width_b, 15);
        chk("b_timeout", timeout_b, 0);
      end else begin
        chk("b_idle_after", {ready_b, done_b}, 2'b10);
      end
    end

    // Random waveforms: runts, long pulses, pre-asserted lines and timeouts
    for (int r = 0; r < 30; r++) begin
      int nseg;
      seq_q.delete();
      init_g = ($urandom_range(0, 3) == 0);
      if (init_g) add_run(1'b1, $urandom_range(0, 6));
      nseg = $urandom_range(1, 3);
      for (int s = 0; s < nseg; s++) begin
        add_run(1'b0, $urandom_range(1, 12));
        if ($urandom_range(0, 1) == 1) add_run(1'b1, $urandom_range(1, 3));
        else add_run(1'b1, $urandom_range(4, 30));
      end
      run_meas("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
